// File: rtl/pdm_pkg.sv
// Shared types for the PDM record/playback buffer.
// Word width and the record/playback FSM state encoding.
package pdm_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        FETCH  = 2'd2,
        PLAY   = 2'd3
    } rec_state_t;

endpackage

// File: rtl/pdm_word_ram.sv
// Single-port word RAM with a synchronous read (one-cycle latency) and unreset contents.
// rdata is updated every cycle from addr, so it stays put while the address is held.
module pdm_word_ram
    import pdm_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pdm_record_buffer.sv
// Records deserializer words into a RAM, then replays them in order on a valid/ready stream.
// Playback: one word per 2 cycles; play_data is held stable while play_ready is low.
module pdm_record_buffer
    import pdm_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              record_start,
    input  logic              play_start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_in,
    output logic              deser_enable,
    output logic [WORD_W-1:0] play_data,
    output logic              play_valid,
    input  logic              play_ready,
    output logic [AW:0]       word_count,
    output logic              full,
    output logic              busy,
    output logic              done_pulse
);

    rec_state_t        state_q;
    logic [AW:0]       word_count_q;
    logic [AW-1:0]     rd_ptr_q;
    logic              done_pulse_q;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [WORD_W-1:0] ram_rdata;
    logic              last_word;
    logic              fill_word;

    // The write pointer always equals the count of words recorded, so it is not stored separately.
    assign ram_we    = (state_q == RECORD) && word_valid && !abort;
    assign ram_addr  = (state_q == RECORD) ? word_count_q[AW-1:0] : rd_ptr_q;
    assign last_word = ({1'b0, rd_ptr_q} == (word_count_q - (AW+1)'(1)));
    assign fill_word = (word_count_q == (AW+1)'(DEPTH - 1));

    pdm_word_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (word_in),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            word_count_q <= '0;
            rd_ptr_q     <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (record_start) begin
                            state_q      <= RECORD;
                            word_count_q <= '0;
                        end else if (play_start && (word_count_q != '0)) begin
                            state_q  <= FETCH;
                            rd_ptr_q <= '0;
                        end
                    end
                    RECORD: begin
                        if (word_valid) begin
                            word_count_q <= word_count_q + (AW+1)'(1);
                            if (fill_word) begin
                                state_q      <= IDLE;
                                done_pulse_q <= 1'b1;
                            end
                        end
                    end
                    FETCH: begin
                        state_q <= PLAY;
                    end
                    PLAY: begin
                        if (play_ready) begin
                            if (last_word) begin
                                state_q      <= IDLE;
                                done_pulse_q <= 1'b1;
                            end else begin
                                rd_ptr_q <= rd_ptr_q + AW'(1);
                                state_q  <= FETCH;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // The RAM read register carries the word; gating by PLAY gives a defined zero outside playback.
    assign play_valid   = (state_q == PLAY);
    assign play_data    = play_valid ? ram_rdata : '0;
    assign deser_enable = (state_q == RECORD);
    assign busy         = (state_q != IDLE);
    assign full         = (word_count_q == (AW+1)'(DEPTH));
    assign word_count   = word_count_q;
    assign done_pulse   = done_pulse_q;

endmodule

// File: tb/tb_pdm_record_buffer.sv
// Bench for pdm_record_buffer (DEPTH=4): directed cases plus randomized record/play passes
// checked against a queue holding the words that should have been captured.
module tb_pdm_record_buffer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        record_start, play_start, abort, word_valid, play_ready;
    logic [15:0] word_in;
    logic        deser_enable, play_valid, full, busy, done_pulse;
    logic [15:0] play_data;
    logic [2:0]  word_count;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] ref_q[$];
    logic [15:0] stim_q[$];

    pdm_record_buffer #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .record_start (record_start),
        .play_start   (play_start),
        .abort        (abort),
        .word_valid   (word_valid),
        .word_in      (word_in),
        .deser_enable (deser_enable),
        .play_data    (play_data),
        .play_valid   (play_valid),
        .play_ready   (play_ready),
        .word_count   (word_count),
        .full         (full),
        .busy         (busy),
        .done_pulse   (done_pulse)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_pv"},   32'(play_valid), 32'(0));
        chk({tag, "_en"},   32'(deser_enable), 32'(0));
        chk({tag, "_done"}, 32'(done_pulse), 32'(0));
    endtask

    // Records stim_q; the model keeps only the first DEPTH words.
    task automatic do_record();
        int  gap;
        bit  just;
        record_start = 1'b1;
        step();
        record_start = 1'b0;
        chk("rec_en0",  32'(deser_enable), 32'(1));
        chk("rec_busy", 32'(busy), 32'(1));
        chk("rec_cnt0", 32'(word_count), 32'(0));
        ref_q.delete();
        foreach (stim_q[i]) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                word_in = 16'($urandom);
                step();
            end
            word_in    = stim_q[i];
            word_valid = 1'b1;
            step();
            word_valid = 1'b0;
            just = 1'b0;
            if (ref_q.size() < DEPTH) begin
                ref_q.push_back(stim_q[i]);
                just = (ref_q.size() == DEPTH);
            end
            chk("rec_cnt",  32'(word_count), 32'(ref_q.size()));
            chk("rec_full", 32'(full), 32'(ref_q.size() == DEPTH));
            chk("rec_done", 32'(done_pulse), 32'(just));
            chk("rec_en",   32'(deser_enable), 32'(ref_q.size() < DEPTH));
        end
        if (ref_q.size() < DEPTH) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk_idle_outputs("abort");
            chk("abort_cnt", 32'(word_count), 32'(ref_q.size()));
        end
    endtask

    // Plays back and checks words against ref_q; rnd selects random play_ready.
    task automatic do_play(input bit rnd);
        int idx;
        bit exp_v;
        bit fin;
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        if (ref_q.size() == 0) begin
            chk_idle_outputs("nplay");
            step();
            chk("nplay_pv2", 32'(play_valid), 32'(0));
            return;
        end
        chk("ply_busy",  32'(busy), 32'(1));
        chk("ply_fetch", 32'(play_valid), 32'(0));
        idx   = 0;
        exp_v = 1'b1;
        fin   = 1'b0;
        for (int c = 0; c < 8 * DEPTH + 40 && !fin; c++) begin
            step();
            if (idx == ref_q.size()) begin
                chk("ply_done",    32'(done_pulse), 32'(1));
                chk("ply_endbusy", 32'(busy), 32'(0));
                chk("ply_endpv",   32'(play_valid), 32'(0));
                fin = 1'b1;
            end else begin
                chk("ply_valid", 32'(play_valid), 32'(exp_v));
                chk("ply_nodone", 32'(done_pulse), 32'(0));
                if (play_valid)
                    chk("ply_data", 32'(play_data), 32'(ref_q[idx]));
                play_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (play_valid && play_ready) begin
                    idx++;
                    exp_v = 1'b0;
                end else begin
                    exp_v = 1'b1;
                end
            end
        end
        play_ready = 1'b0;
        chk("ply_finished", 32'(fin), 32'(1));
        step();
        chk("ply_after_pv",   32'(play_valid), 32'(0));
        chk("ply_after_done", 32'(done_pulse), 32'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        record_start = 1'b0; play_start = 1'b0; abort = 1'b0;
        word_valid = 1'b0; word_in = 16'h0; play_ready = 1'b0;
        step(); step();
        chk_idle_outputs("rst");
        chk("rst_data", 32'(play_data), 32'(0));
        chk("rst_cnt",  32'(word_count), 32'(0));
        chk("rst_full", 32'(full), 32'(0));
        #4 reset_n = 1'b1;
        step();

        // play with nothing recorded is ignored
        ref_q.delete();
        do_play(1'b0);

        // partial record then abort, fixed-ready playback checks the 2-cycle cadence
        stim_q = '{16'hA5A5, 16'h0001, 16'hFFFF};
        do_record();
        do_play(1'b0);

        // word_valid while idle must not disturb the stored words
        word_valid = 1'b1; word_in = 16'h1234;
        step(); step();
        word_valid = 1'b0;
        chk("idle_wv_cnt", 32'(word_count), 32'(3));
        do_play(1'b1);

        // fill: five strobes, only four stored
        stim_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        do_record();
        chk("fill_cnt", 32'(word_count), 32'(DEPTH));
        do_play(1'b1);

        // backpressure: hold play_ready low for 10 cycles in PLAY
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        step();
        for (int k = 0; k < 10; k++) begin
            chk("bp_pv",   32'(play_valid), 32'(1));
            chk("bp_data", 32'(play_data), 32'(ref_q[0]));
            step();
        end
        play_ready = 1'b1;
        step();
        play_ready = 1'b0;
        chk("bp_fetch", 32'(play_valid), 32'(0));
        step();
        chk("bp_next_pv",   32'(play_valid), 32'(1));
        chk("bp_next_data", 32'(play_data), 32'(ref_q[1]));
        step();
        chk("bp_hold_data", 32'(play_data), 32'(ref_q[1]));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle_outputs("bp_abort");
        chk("bp_abort_cnt", 32'(word_count), 32'(DEPTH));

        // simultaneous starts with three words stored: record wins
        stim_q = '{16'($urandom), 16'($urandom), 16'($urandom)};
        do_record();
        record_start = 1'b1;
        play_start   = 1'b1;
        step();
        record_start = 1'b0;
        play_start   = 1'b0;
        chk("both_en",  32'(deser_enable), 32'(1));
        chk("both_cnt", 32'(word_count), 32'(0));
        chk("both_pv",  32'(play_valid), 32'(0));
        step();
        chk("both_pv2", 32'(play_valid), 32'(0));
        abort = 1'b1;
        step();
        abort = 1'b0;
        ref_q.delete();
        chk("both_abort_cnt", 32'(word_count), 32'(0));
        do_play(1'b0);

        // randomized passes
        for (int it = 0; it < 10; it++) begin
            int n;
            n = $urandom_range(1, DEPTH + 2);
            stim_q.delete();
            for (int j = 0; j < n; j++) stim_q.push_back(16'($urandom));
            do_record();
            do_play(1'b1);
        end

        // asynchronous reset during playback
        stim_q = '{16'hBEEF, 16'hCAFE};
        do_record();
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        step();
        chk("rmid_pv_before", 32'(play_valid), 32'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("rmid_pv",   32'(play_valid), 32'(0));
        chk("rmid_busy", 32'(busy), 32'(0));
        chk("rmid_cnt",  32'(word_count), 32'(0));
        chk("rmid_data", 32'(play_data), 32'(0));
        #2 reset_n = 1'b1;
        step();
        chk_idle_outputs("rmid_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
